// File: rtl/dmem_bridge_if.sv
// Memory-stage / memory-bus signal bundle for dmem_bridge.
// master = bridge view, slave = pipeline + memory view.
interface dmem_bridge_if;
   logic        re;
   logic [3:0]  we;
   logic [29:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        stall;
   logic        bus_valid;
   logic        bus_ready;
   logic [3:0]  bus_we;
   logic [29:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_rvalid;
   logic [31:0] bus_rdata;
   logic        bus_err;

   modport master (
      input  re, we, addr, wdata, bus_ready, bus_rvalid, bus_rdata,
      output rdata, stall, bus_valid, bus_we, bus_addr, bus_wdata, bus_err
   );

   modport slave (
      output re, we, addr, wdata, bus_ready, bus_rvalid, bus_rdata,
      input  rdata, stall, bus_valid, bus_we, bus_addr, bus_wdata, bus_err
   );
endinterface

// File: rtl/dmem_bridge.sv
// Single-outstanding data-memory bridge between the memory stage and a valid/ready bus.
// Optional REQ+WAIT abort timer enabled by defining DMEM_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no transaction; latch a pending request into bus_* regs
// REQ   | bus_valid high until the bus accepts
// WAIT  | accepted, waiting for bus_rvalid
// DONE  | one-cycle stall release; bus_err pulses here on abort
module dmem_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic          clk,
   input  logic          reset,
   dmem_bridge_if.master bus
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t state;
   logic   req;
   logic   is_read;
   logic   timeout;

   assign req       = bus.re | (bus.we != 4'b0000);
   assign bus.stall = req & (state != DONE);
   assign is_read   = (bus.bus_we == 4'b0000);

`ifdef DMEM_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] to_cnt;
   logic       err;

   assign timeout     = (to_cnt == TO_LAST);
   assign bus.bus_err = err;
`else
   assign timeout     = 1'b0;
   assign bus.bus_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         bus.rdata     <= 32'h0;
         bus.bus_valid <= 1'b0;
         bus.bus_we    <= 4'b0000;
         bus.bus_addr  <= 30'h0;
         bus.bus_wdata <= 32'h0;
`ifdef DMEM_TIMEOUT_EN
         to_cnt        <= 8'd0;
         err           <= 1'b0;
`endif
      end else begin
`ifdef DMEM_TIMEOUT_EN
         err <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (req) begin
                  bus.bus_addr  <= bus.addr;
                  bus.bus_wdata <= bus.wdata;
                  bus.bus_we    <= bus.we;
                  bus.bus_valid <= 1'b1;
`ifdef DMEM_TIMEOUT_EN
                  to_cnt        <= 8'd0;
`endif
                  state         <= REQ;
               end
            end

            REQ: begin
               // a same-cycle completion takes priority over the abort timer
               if (bus.bus_ready && bus.bus_rvalid) begin
                  if (is_read) bus.rdata <= bus.bus_rdata;
                  bus.bus_valid <= 1'b0;
                  state         <= DONE;
               end else if (timeout) begin
                  if (is_read) bus.rdata <= 32'hFFFF_FFFF;
                  bus.bus_valid <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
                  err           <= 1'b1;
`endif
                  state         <= DONE;
               end else begin
                  if (bus.bus_ready) begin
                     bus.bus_valid <= 1'b0;
                     state         <= WAIT;
                  end
`ifdef DMEM_TIMEOUT_EN
                  to_cnt <= to_cnt + 8'd1;
`endif
               end
            end

            WAIT: begin
               if (bus.bus_rvalid) begin
                  if (is_read) bus.rdata <= bus.bus_rdata;
                  state <= DONE;
               end else if (timeout) begin
                  if (is_read) bus.rdata <= 32'hFFFF_FFFF;
`ifdef DMEM_TIMEOUT_EN
                  err   <= 1'b1;
`endif
                  state <= DONE;
               end else begin
`ifdef DMEM_TIMEOUT_EN
                  to_cnt <= to_cnt + 8'd1;
`endif
               end
            end

            DONE: begin
               state <= IDLE;
            end

            default: begin
               state         <= IDLE;
               bus.bus_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: directed cases plus randomized transactions
// against a cycle-count / last-read-data reference model.
module tb_dmem_bridge;

`ifdef DMEM_TIMEOUT_EN
   localparam int TO = 4;
`else
   localparam int TO = 255;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   dmem_bridge_if dif ();

   dmem_bridge #(.TIMEOUT_CYCLES(TO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (dif)
   );

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_rdata = 32'h0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   // One transaction starting in IDLE at a negedge. The bus accepts in REQ cycle rd
   // (0-based); vd==0 means the ack comes with the accept, otherwise vd WAIT cycles later.
   // Expected: stall high through cycle 1+rd+vd, DONE (stall low) at cycle 2+rd+vd.
   task automatic txn(input logic r, input logic [3:0] w, input logic [29:0] a,
                      input logic [31:0] d, input int rd, input int vd,
                      input logic [31:0] rsp, input bit hold);
      dif.re = r; dif.we = w; dif.addr = a; dif.wdata = d;
      #1;
      chk("idle_stall", dif.stall, 1);
      chk("idle_valid", dif.bus_valid, 0);
      cyc();
      for (int k = 0; k <= rd; k++) begin
         chk("req_valid", dif.bus_valid, 1);
         chk("req_stall", dif.stall, 1);
         chk("req_addr",  dif.bus_addr, a);
         chk("req_we",    dif.bus_we, w);
         chk("req_wdata", dif.bus_wdata, d);
         dif.addr      = 30'($urandom);
         dif.wdata     = $urandom;
         dif.bus_ready = (k == rd);
         dif.bus_rvalid = (k < rd) ? 1'($urandom % 2) : (vd == 0);
         dif.bus_rdata = (k == rd && vd == 0) ? rsp : $urandom;
         cyc();
      end
      dif.bus_ready = 0; dif.bus_rvalid = 0;
      for (int k = 1; k <= vd; k++) begin
         chk("wait_valid", dif.bus_valid, 0);
         chk("wait_stall", dif.stall, 1);
         dif.bus_rvalid = (k == vd);
         dif.bus_rdata  = (k == vd) ? rsp : $urandom;
         cyc();
         dif.bus_rvalid = 0;
      end
      if (w == 4'b0000) exp_rdata = rsp;
      chk("done_stall", dif.stall, 0);
      chk("done_rdata", dif.rdata, exp_rdata);
      chk("done_err",   dif.bus_err, 0);
      chk("done_valid", dif.bus_valid, 0);
      if (!hold) begin dif.re = 0; dif.we = 0; end
      dif.bus_rvalid = 1'($urandom % 2);
      dif.bus_rdata  = $urandom;
      cyc();
      dif.bus_rvalid = 0;
      chk("post_rdata", dif.rdata, exp_rdata);
      chk("post_valid", dif.bus_valid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int rd, vd;
      logic r;
      logic [3:0] w;

      reset = 1;
      dif.re = 1; dif.we = 0; dif.addr = 30'h3; dif.wdata = 32'h0;
      dif.bus_ready = 0; dif.bus_rvalid = 0; dif.bus_rdata = 32'h0;

      // reset held two cycles with a read pending
      repeat (2) cyc();
      chk("rst_rdata", dif.rdata, 0);
      chk("rst_valid", dif.bus_valid, 0);
      chk("rst_err",   dif.bus_err, 0);
      chk("rst_stall", dif.stall, 1);
      chk("rst_bwe",   dif.bus_we, 0);
      chk("rst_baddr", dif.bus_addr, 0);
      reset = 0;
      cyc();
      chk("rel_req_valid", dif.bus_valid, 1);
      chk("rel_req_addr",  dif.bus_addr, 30'h3);
      reset = 1;
      cyc();
      reset = 0; dif.re = 0;
      chk("rst_req_valid", dif.bus_valid, 0);
      cyc();

      // read with ack three cycles after accept (also the exact timeout boundary when enabled)
      txn(1'b1, 4'b0000, 30'h100, 32'h0, 0, 3, 32'hDEADBEEF, 1'b0);
      // write with accept and ack together
      txn(1'b0, 4'b0011, 30'h2A, 32'h12345678, 0, 0, 32'hCAFE0000, 1'b0);
      // re and we together behaves as a write
      txn(1'b1, 4'b1000, 30'h55, 32'hA5A5A5A5, 1, 1, 32'h0BADF00D, 1'b0);
      // back-to-back read then write, request held
      txn(1'b1, 4'b0000, 30'h200, 32'h0, 1, 0, 32'h11112222, 1'b1);
      txn(1'b0, 4'b1111, 30'h204, 32'h33334444, 0, 2, 32'h55556666, 1'b0);

      // reset in WAIT, then stray acks must not complete anything
      dif.re = 1; dif.we = 0; dif.addr = 30'h77;
      cyc();
      dif.bus_ready = 1;
      cyc();
      dif.bus_ready = 0;
      chk("w_valid", dif.bus_valid, 0);
      reset = 1;
      cyc();
      reset = 0;
      exp_rdata = 32'h0;
      #1;
      chk("wr_stall", dif.stall, 1);
      chk("wr_valid", dif.bus_valid, 0);
      chk("wr_rdata", dif.rdata, 0);
      dif.bus_rvalid = 1; dif.bus_rdata = 32'h5;
      cyc();
      chk("wr_req_valid", dif.bus_valid, 1);
      chk("wr_req_stall", dif.stall, 1);
      chk("wr_req_rdata", dif.rdata, 0);
      cyc();
      chk("wr_req2_stall", dif.stall, 1);
      chk("wr_req2_rdata", dif.rdata, 0);
      dif.bus_ready = 1; dif.bus_rdata = 32'h9;
      cyc();
      dif.bus_ready = 0; dif.bus_rvalid = 0;
      exp_rdata = 32'h9;
      chk("wr_done_stall", dif.stall, 0);
      chk("wr_done_rdata", dif.rdata, exp_rdata);
      dif.re = 0;
      cyc();

      // randomized transactions
      for (int n = 0; n < 24; n++) begin
         r  = 1'($urandom % 2);
         w  = ($urandom % 2) ? 4'($urandom) : 4'b0000;
         if (!r && w == 4'b0000) r = 1'b1;
         rd = int'($urandom_range(0, 3));
         vd = int'($urandom_range(0, 3));
         if (TO == 4 && rd + vd > 3) vd = 3 - rd;
         txn(r, w, 30'($urandom), $urandom, rd, vd, $urandom, 1'($urandom % 2));
      end
      dif.re = 0; dif.we = 0;
      cyc();

`ifdef DMEM_TIMEOUT_EN
      // read never accepted: abort after TO cycles in REQ
      dif.re = 1; dif.we = 0; dif.addr = 30'h123;
      cyc();
      for (int k = 0; k < TO; k++) begin
         chk("to_req_valid", dif.bus_valid, 1);
         chk("to_req_stall", dif.stall, 1);
         chk("to_req_err",   dif.bus_err, 0);
         cyc();
      end
      exp_rdata = 32'hFFFF_FFFF;
      chk("to_done_stall", dif.stall, 0);
      chk("to_done_err",   dif.bus_err, 1);
      chk("to_done_rdata", dif.rdata, exp_rdata);
      chk("to_done_valid", dif.bus_valid, 0);
      dif.re = 0;
      cyc();
      chk("to_post_err", dif.bus_err, 0);

      // write accepted but never acked: abort from WAIT, rdata untouched
      exp_rdata = 32'h1357_9BDF;
      txn(1'b1, 4'b0000, 30'h1, 32'h0, 0, 0, exp_rdata, 1'b0);
      dif.we = 4'b0101; dif.addr = 30'h321; dif.wdata = 32'h0F0F0F0F;
      cyc();
      dif.bus_ready = 1;
      cyc();
      dif.bus_ready = 0;
      for (int k = 1; k < TO; k++) begin
         chk("tow_stall", dif.stall, 1);
         chk("tow_err",   dif.bus_err, 0);
         cyc();
      end
      chk("tow_done_stall", dif.stall, 0);
      chk("tow_done_err",   dif.bus_err, 1);
      chk("tow_done_rdata", dif.rdata, exp_rdata);
      dif.we = 0;
      cyc();
      chk("tow_post_err", dif.bus_err, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
